hazard_mem_ctrl: RTL
====================

// Module: hazard_mem_ctrl
// PURPOSE
// Pipeline sequencing controller for the rv32i 5-stage core (F/D/E/M/W).
// - Computes E-stage operand forwarding selects.
// - Generates load-use stalls and branch flushes.
// - Runs a data-memory req/ack FSM that freezes the whole pipeline,
//   including the writeback-stage registers, while a load/store in M waits.
// - Sits beside the datapath and drives every stage-register enable/clear.
// PARAMETERS
// TIMEOUT_CYC  64  max WAIT cycles before dmem_err_o; 16-bit counter; must be 1..65535
// PORTS
// clk          in   1  core clock, rising edge
// rst_n        in   1  asynchronous active-low reset
// Rs1D,Rs2D    in   5  source regs of instruction in D
// Rs1E,Rs2E    in   5  source regs of instruction in E
// RdE,RdM,RdW  in   5  dest regs in E/M/W
// resultsrcE   in   1  E instruction is a load (result from memory)
// regwriteM    in   1  M instruction writes the register file
// regwriteW    in   1  W instruction writes the register file
// pcsrcE       in   1  branch/jump taken, resolved in E
// memreqM      in   1  M instruction is a load or store
// dmem_ack_i   in   1  data memory completes the access this cycle
// dmem_req_o   out  1  data memory request, held high until ack
// forwardAE    out  2  00 regfile, 10 aluresultM, 01 resultW (operand A)
// forwardBE    out  2  same encoding, operand B
// stallF,stallD out 1  hold PC / F-D register
// stallE,stallM,stallW out 1  hold E / M / W registers
// flushD,flushE out 1  clear D / E register to a bubble
// busy_o       out  1  FSM not in IDLE
// dmem_err_o   out  1  sticky: memory timeout occurred
// BEHAVIOUR
// Forwarding (combinational, per operand, shown for A):
// - 10 if regwriteM && RdM!=0 && RdM==Rs1E.
// - Else 01 if regwriteW && RdW!=0 && RdW==Rs1E.
// - Else 00. M has priority over W. x0 is never forwarded.
// Load-use (combinational):
// - lwstall = resultsrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
// - Response: stallF=stallD=1, flushE=1.
// Branch: pcsrcE drives flushD=flushE=1.
// Memory FSM states:
// - IDLE: if memreqM, dmem_req_o=1.
//   - With dmem_ack_i the same cycle: no stall, stay IDLE (zero-wait access).
//   - Without ack: memstall=1, go WAIT, cnt<=1.
// - WAIT: dmem_req_o=1.
//   - On dmem_ack_i: memstall=0 this cycle, M advances to W at the edge, go IDLE.
//   - Else: memstall=1, cnt<=cnt+1.
//   - When cnt==TIMEOUT_CYC with no ack: go ERR.
// - ERR: dmem_req_o=0, memstall=1 forever, dmem_err_o=1. Exit only via reset.
// Memstall effects:
// - stallF..stallW all =1; flushD=flushE=0 (suppressed).
// - lwstall and pcsrcE are held pending. They are re-evaluated on the first cycle memstall=0.
// Simultaneous events:
// - Branch and load-use in the same cycle: flushD=flushE=1, stallF=stallD=1.
//   The branch target still loads because pcsrcE overrides stallF in the PC mux.
// - stallE/stallM/stallW are driven only by memstall.
// busy_o=1 in WAIT and ERR.
// Reset (async assert, sync deassert handled upstream):
// - state=IDLE, cnt=0, dmem_err_o=0.
// - Combinational outputs follow the inputs. With all inputs 0, every output is 0.
// - Reset during WAIT drops dmem_req_o immediately. The memory side must discard the access.
// TESTING
// 1 Forward priority: RdM=RdW=Rs1E=5, both regwrite=1 -> forwardAE=10.
//   Same with RdM=RdW=Rs1E=0 -> forwardAE=00.
// 2 Load-use: resultsrcE=1, RdE=7, Rs2D=7 -> stallF=stallD=flushE=1, one cycle only.
//   Same with RdE=0 -> no stall.
// 3 Branch: pcsrcE=1 for 1 cycle -> flushD=flushE=1 that cycle, no stalls.
// 4 Memory wait: memreqM=1, ack after 3 cycles.
//   -> dmem_req_o high 4 cycles, stallF..W high 3 cycles, low on the ack cycle, back to IDLE.
//   Zero-wait ack -> no stall.
// 5 Timeout: TIMEOUT_CYC=4, no ack -> ERR after cycle 4, dmem_err_o=1 sticky, all stalls stuck high.
// 6 Reset in WAIT: rst_n=0 mid-wait -> dmem_req_o, busy_o, stalls low asynchronously.
//   Then pcsrcE pending during the wait -> flush occurs on the ack cycle.

Source files
------------

// File: rtl/hazard_mem_ctrl.sv
// Pipeline sequencing controller for the 5-stage rv32i core: E-stage operand
// forwarding, load-use stalls, branch flushes, and a data-memory req/ack FSM
// that freezes every stage register while an access in M is outstanding.
module hazard_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       resultsrcE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       pcsrcE,
  input  logic       memreqM,
  input  logic       dmem_ack_i,
  output logic       dmem_req_o,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       busy_o,
  output logic       dmem_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYC);

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_err, w_err_d;
  logic        w_memstall;
  logic        w_lwstall;

  // M has priority over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Operand forwarding selects.
  always_comb begin
    forwardAE = fwd_sel(Rs1E, regwriteM, RdM, regwriteW, RdW);
    forwardBE = fwd_sel(Rs2E, regwriteM, RdM, regwriteW, RdW);
  end

  // Memory FSM next state, request and memstall.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_memstall = 1'b0;
    dmem_req_o = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (memreqM) begin
          dmem_req_o = 1'b1;
          if (!dmem_ack_i) begin
            w_memstall = 1'b1;
            w_state_d  = StWait;
            w_cnt_d    = 16'd1;
          end
        end
      end
      StWait: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          w_state_d = StIdle;
          w_cnt_d   = 16'd0;
        end else begin
          w_memstall = 1'b1;
          if (r_cnt == TimeoutCnt) begin
            w_state_d = StErr;
          end else begin
            w_cnt_d = r_cnt + 16'd1;
          end
        end
      end
      StErr: begin
        w_memstall = 1'b1;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_err_d = r_err | (w_state_d == StErr);
  end

  // Stall/flush generation; while memstall is high the pipeline is frozen, so
  // load-use and branch requests stay on the inputs and resolve once it drops.
  always_comb begin
    w_lwstall = resultsrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    stallF    = w_memstall | w_lwstall;
    stallD    = w_memstall | w_lwstall;
    stallE    = w_memstall;
    stallM    = w_memstall;
    stallW    = w_memstall;
    flushD    = !w_memstall && pcsrcE;
    flushE    = !w_memstall && (pcsrcE || w_lwstall);
    busy_o    = (r_state != StIdle);
    dmem_err_o = r_err;
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

endmodule
